// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM encoding, grant source
// and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gntSrc_t;

    function automatic logic isBusy(input arbState_t s);
        return (s == I_BUSY) || (s == D_BUSY);
    endfunction

endpackage

// File: rtl/mem_port_watchdog.sv
// Saturating count of BUSY cycles without an acknowledge; raises a sticky
// err flag once the count reaches TIMEOUT.
module mem_port_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] countR;
    logic          bumpS;

    // Advance only while waiting, and stop at the limit so the count never wraps.
    always_comb begin
        bumpS = busy && !ack && (countR != LIMIT);
    end

    // Counter is zero whenever no access is in flight, so every access starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countR <= '0;
            err    <= 1'b0;
        end else if (!busy) begin
            countR <= '0;
        end else if (bumpS) begin
            countR <= countR + CW'(1);
            if (countR == (LIMIT - CW'(1))) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one req/ack
// memory port; data side has fixed priority as it carries the older instruction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_wstrb,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            err
);

    arbState_t stateR;
    gntSrc_t   ackSrcS;
    logic      busyS;

    // Decode the owner of the in-flight access and the pipeline stall requests.
    always_comb begin
        busyS     = isBusy(stateR);
        ackSrcS   = (stateR == D_BUSY) ? GNT_D : GNT_I;
        stall_if  = i_req & ~i_ready;
        stall_mem = d_req & ~d_ready;
    end

    // Arbitration FSM; request fields are captured at grant so requesters may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR    <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (d_req) begin
                        stateR    <= D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_wstrb <= d_wstrb;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (i_req) begin
                        stateR    <= I_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        stateR  <= RESP;
                        if (ackSrcS == GNT_D) begin
                            d_ready <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    stateR  <= IDLE;
                end
                default: begin
                    stateR <= IDLE;
                end
            endcase
        end
    end

    mem_port_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) uWatchdog (
        .clk (clk),
        .rst (rst),
        .busy(busyS),
        .ack (mem_ack),
        .err (err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory
// issues and ready responses, monitors compare them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, i_ready, d_req, d_we, d_ready;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb, mem_wstrb;
    logic          mem_req, mem_we, mem_ack, stall_if, stall_mem, err;

    typedef struct {
        logic          isD;
        logic [AW-1:0] addr;
        logic          we;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
    } issue_t;

    typedef struct {
        logic          isD;
        logic [DW-1:0] data;
    } resp_t;

    issue_t        issueQ[$];
    resp_t         respQ[$];
    issue_t        cur;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            issueCount = 0;
    int            ackDelay = 0;
    int            waitCnt = 0;
    logic          memEnable = 1'b1;
    logic [DW-1:0] rdataNext = '0;
    logic [DW-1:0] modelD = '0;
    logic          prevReq = 1'b0;
    logic          prevAck = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acks after ackDelay idle cycles of mem_req, unless disabled.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end else if (mem_req && memEnable) begin
                if (waitCnt >= ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdataNext;
                end else begin
                    waitCnt = waitCnt + 1;
                end
            end
        end
    end

    // Monitor: stalls, issued accesses, held mem_* fields and ready responses.
    always @(negedge clk) begin
        resp_t r;
        check("stall_if", 64'(stall_if), 64'(i_req & ~i_ready));
        check("stall_mem", 64'(stall_mem), 64'(d_req & ~d_ready));
        if (mem_req && !prevReq) begin
            issueCount = issueCount + 1;
            if (issueQ.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_mem_req: got addr %0h expected none", mem_addr);
            end else begin
                cur = issueQ.pop_front();
                check("issue_addr", 64'(mem_addr), 64'(cur.addr));
                check("issue_we", 64'(mem_we), 64'(cur.we));
                check("issue_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
                if (cur.isD) check("issue_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
        end else if (mem_req && prevReq) begin
            check("hold_addr", 64'(mem_addr), 64'(cur.addr));
            check("hold_we", 64'(mem_we), 64'(cur.we));
            check("hold_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
            if (cur.isD) check("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
        if (i_ready || d_ready) begin
            check("ready_after_ack", 64'(prevAck), 64'd1);
            check("single_ready", 64'(i_ready & d_ready), 64'd0);
            if (respQ.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_ready: got i=%0d d=%0d expected none", i_ready, d_ready);
            end else begin
                r = respQ.pop_front();
                check("ready_port", 64'(d_ready), 64'(r.isD));
                check("ready_rdata", r.isD ? 64'(d_rdata) : 64'(i_rdata), 64'(r.data));
            end
        end
        prevReq = mem_req;
        prevAck = mem_ack;
    end

    task automatic reqI(input logic [AW-1:0] a, input logic [DW-1:0] rd);
        issue_t e;
        resp_t  r;
        e.isD = 1'b0; e.addr = a; e.we = 1'b0; e.wstrb = '0; e.wdata = '0;
        r.isD = 1'b0; r.data = rd;
        issueQ.push_back(e);
        respQ.push_back(r);
        rdataNext = rd;
        i_addr = a;
        i_req = 1'b1;
    endtask

    task automatic reqD(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [DW-1:0] rd, input bit expectResp);
        issue_t e;
        resp_t  r;
        e.isD = 1'b1; e.addr = a; e.we = we; e.wstrb = ws; e.wdata = wd;
        issueQ.push_back(e);
        if (!we) modelD = rd;
        r.isD = 1'b1; r.data = modelD;
        if (expectResp) respQ.push_back(r);
        rdataNext = rd;
        d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
        d_req = 1'b1;
    endtask

    task automatic waitReady(input bit isD, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((isD && d_ready) || (!isD && i_ready)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL wait_ready_%s: got no pulse expected one within %0d cycles", isD ? "d" : "i", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int c0, ta, tb, n0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_i_rdata", 64'(i_rdata), 64'd0);
        check("rst_d_rdata", 64'(d_rdata), 64'd0);
        check("rst_ready", 64'({i_ready, d_ready}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk); #3 rst = 1'b0;

        // Single fetch, ack one cycle into mem_req: ready three cycles after request.
        @(posedge clk); #2;
        c0 = cyc; ackDelay = 1;
        reqI(32'hBFC0_0000, 32'h3C08_BFAF);
        @(negedge clk);
        check("fetch_stall_if", 64'(stall_if), 64'd1);
        waitReady(1'b0, 20, ta);
        check("fetch_latency", 64'(ta - c0), 64'd3);
        @(posedge clk); #2 i_req = 1'b0;

        // Simultaneous store and fetch: store first, fetch at least 3 cycles later.
        @(posedge clk); #2;
        ackDelay = 0;
        reqD(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h5555_5555, 1'b1);
        reqI(32'h0000_0200, 32'h1111_2222);
        waitReady(1'b1, 20, ta);
        @(posedge clk); #2 d_req = 1'b0;
        waitReady(1'b0, 20, tb);
        check("fetch_after_store_gap", 64'(tb - ta >= 3), 64'd1);
        @(posedge clk); #2 i_req = 1'b0;

        // Load, then a byte store with 3 wait cycles that must leave d_rdata alone.
        @(posedge clk); #2;
        ackDelay = 0;
        reqD(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
        waitReady(1'b1, 20, ta);
        @(posedge clk); #2 d_req = 1'b0;
        @(posedge clk); #2;
        ackDelay = 3;
        reqD(1'b1, 32'h0000_0104, 32'h0000_AB00, 4'h2, 32'h9999_6666, 1'b1);
        waitReady(1'b1, 20, ta);
        @(posedge clk); #2 d_req = 1'b0;

        // Fetch flushed after grant still completes, with exactly one issue.
        @(posedge clk); #2;
        n0 = issueCount; ackDelay = 2;
        reqI(32'h0000_0300, 32'h0BAD_C0DE);
        @(posedge clk);
        @(posedge clk); #2 i_req = 1'b0;
        waitReady(1'b0, 20, ta);
        repeat (5) @(negedge clk);
        check("flush_single_issue", 64'(issueCount - n0), 64'd1);
        check("flush_idle_req", 64'(mem_req), 64'd0);
        check("err_quiet", 64'(err), 64'd0);

        // Watchdog: no ack for 4 BUSY cycles sets err; late ack completes normally.
        @(posedge clk); #2;
        memEnable = 1'b0;
        reqD(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'h1234_5678, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wd_err_before", 64'(err), 64'd0);
        @(negedge clk);
        check("wd_err_set", 64'(err), 64'd1);
        check("wd_req_held", 64'(mem_req), 64'd1);
        repeat (2) @(negedge clk);
        check("wd_req_still_held", 64'(mem_req), 64'd1);
        ackDelay = 0; memEnable = 1'b1;
        waitReady(1'b1, 20, ta);
        check("wd_err_sticky", 64'(err), 64'd1);
        @(posedge clk); #2 d_req = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_err_sticky_idle", 64'(err), 64'd1);

        // Asynchronous reset while D_BUSY, then a normal access.
        @(posedge clk); #2;
        memEnable = 1'b0;
        reqD(1'b0, 32'h0000_0500, 32'h0, 4'h0, 32'h7777_7777, 1'b0);
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_d_ready", 64'(d_ready), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_d_rdata", 64'(d_rdata), 64'd0);
        modelD = '0;
        d_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        memEnable = 1'b1; ackDelay = 0;
        @(posedge clk); #2;
        reqD(1'b0, 32'h0000_0600, 32'h0, 4'h0, 32'h600D_DA7A, 1'b1);
        waitReady(1'b1, 20, ta);
        @(posedge clk); #2 d_req = 1'b0;

        repeat (3) @(negedge clk);
        check("issue_queue_drained", 64'(issueQ.size()), 64'd0);
        check("resp_queue_drained", 64'(respQ.size()), 64'd0);
        check("err_after_reset", 64'(err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
